// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: one fetch per cycle from a combinational ROM, registered output with valid/ready.
// Defining IFC_HALT_EN stops fetch at PC_LIMIT; otherwise the PC runs freely and wraps modulo 2^32.
module inst_fetch_ctrl #(
   parameter logic [31:0] PC_LIMIT = 32'h0000_0080
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] pc_addr_o,
   input  logic [31:0] rom_inst_i,
   output logic [31:0] inst_out_o,
   output logic [31:0] inst_pc_o,
   output logic        inst_valid_o,
   input  logic        inst_ready_i,
   input  logic        stall_i,
   input  logic        br_taken_i,
   input  logic [31:0] br_target_i,
   output logic        halted_o
);

   typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

   state_t      state_q;
   logic [31:0] pc_q;
   logic [31:0] pc_d;
   logic [31:0] inst_q;
   logic [31:0] inst_pc_q;
   logic        valid_q;
   logic        halted_q;
   logic        transfer;
   logic        fetch_slot;
   logic        at_limit;

   assign transfer   = valid_q && inst_ready_i && !br_taken_i;
   assign fetch_slot = !stall_i && (!valid_q || transfer);
   assign pc_d       = pc_q + 32'd4;

`ifdef IFC_HALT_EN
   assign at_limit = (pc_q >= PC_LIMIT);
`else
   // Halt detection compiled out: the limit compare is masked to a constant 0.
   assign at_limit = &{1'b0, (pc_q >= PC_LIMIT)};
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         pc_q      <= 32'd0;
         inst_q    <= 32'd0;
         inst_pc_q <= 32'd0;
         valid_q   <= 1'b0;
         halted_q  <= 1'b0;
      end else if (br_taken_i) begin
         pc_q     <= {br_target_i[31:2], 2'b00};
         valid_q  <= 1'b0;
         halted_q <= 1'b0;
         state_q  <= FETCH;
      end else begin
         case (state_q)
            IDLE: state_q <= FETCH;
            FETCH: begin
               // A slot opens only when the output register is empty or being drained.
               if (fetch_slot) begin
                  if (at_limit) begin
                     state_q  <= HALT;
                     halted_q <= 1'b1;
                     valid_q  <= 1'b0;
                  end else begin
                     inst_q    <= rom_inst_i;
                     inst_pc_q <= pc_q;
                     valid_q   <= 1'b1;
                     pc_q      <= pc_d;
                  end
               end
            end
            HALT: begin
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pc_addr_o    = pc_q;
   assign inst_out_o   = inst_q;
   assign inst_pc_o    = inst_pc_q;
   assign inst_valid_o = valid_q;
   assign halted_o     = halted_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl; transfers are checked against a queue of expected fetch addresses.
module tb_inst_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] pc_addr;
   logic [31:0] rom_inst;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic        halted;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];

   always #5 clk = ~clk;

   inst_fetch_ctrl #(.PC_LIMIT(32'h0000_0038)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .pc_addr_o    (pc_addr),
      .rom_inst_i   (rom_inst),
      .inst_out_o   (inst_out),
      .inst_pc_o    (inst_pc),
      .inst_valid_o (inst_valid),
      .inst_ready_i (inst_ready),
      .stall_i      (stall),
      .br_taken_i   (br_taken),
      .br_target_i  (br_target),
      .halted_o     (halted)
   );

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: rom_word = 32'h3C01_1111;
         32'h0000_0004: rom_word = 32'h3C02_2222;
         default:       rom_word = a ^ 32'hA5A5_0000;
      endcase
   endfunction

   assign rom_inst = rom_word(pc_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every accepted instruction must match the next expected address and its ROM word.
   always @(negedge clk) begin : sb_mon
      logic [31:0] e;
      if (!rst && !stall && !br_taken && inst_valid && inst_ready) begin
         chk("sb_have_expect", {31'd0, exp_q.size() != 0}, 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_pc", inst_pc, e);
            chk("sb_inst", inst_out, rom_word(e));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst        = 1'b1;
      inst_ready = 1'b1;
      stall      = 1'b0;
      br_taken   = 1'b0;
      br_target  = 32'd0;
      step();
      step();
      chk("rst_pc", pc_addr, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_out", inst_out, 32'd0);
      chk("rst_ipc", inst_pc, 32'd0);
      chk("rst_halt", {31'd0, halted}, 32'd0);

      exp_q.push_back(32'h0);
      exp_q.push_back(32'h4);
      exp_q.push_back(32'h8);
      rst = 1'b0;
      step();
      chk("idle_valid", {31'd0, inst_valid}, 32'd0);
      chk("idle_pc", pc_addr, 32'd0);
      step();
      chk("c2_out", inst_out, 32'h3C01_1111);
      chk("c2_ipc", inst_pc, 32'h0);
      chk("c2_valid", {31'd0, inst_valid}, 32'd1);
      step();
      chk("c3_out", inst_out, 32'h3C02_2222);
      chk("c3_ipc", inst_pc, 32'h4);
      step();
      chk("c4_ipc", inst_pc, 32'h8);

      inst_ready = 1'b0;
      repeat (3) begin
         step();
         chk("bp_ipc", inst_pc, 32'h8);
         chk("bp_out", inst_out, rom_word(32'h8));
         chk("bp_pcaddr", pc_addr, 32'hC);
         chk("bp_valid", {31'd0, inst_valid}, 32'd1);
      end
      inst_ready = 1'b1;
      step();
      chk("bp_next_ipc", inst_pc, 32'hC);

      stall = 1'b1;
      repeat (2) step();
      chk("st_ipc", inst_pc, 32'hC);
      chk("st_pcaddr", pc_addr, 32'h10);
      chk("st_valid", {31'd0, inst_valid}, 32'd1);

      br_taken  = 1'b1;
      br_target = 32'h0000_002F;
      step();
      br_taken = 1'b0;
      stall    = 1'b0;
      chk("br_valid", {31'd0, inst_valid}, 32'd0);
      chk("br_pcaddr", pc_addr, 32'h2C);
      exp_q.push_back(32'h2C);
      step();
      chk("br_ipc", inst_pc, 32'h2C);
      chk("br_valid2", {31'd0, inst_valid}, 32'd1);
      step();
      chk("br_ipc_next", inst_pc, 32'h30);
      inst_ready = 1'b0;

`ifndef IFC_HALT_EN
      br_taken  = 1'b1;
      br_target = 32'hFFFF_FFFC;
      step();
      br_taken = 1'b0;
      chk("wr_pcaddr0", pc_addr, 32'hFFFF_FFFC);
      exp_q.push_back(32'hFFFF_FFFC);
      exp_q.push_back(32'h0);
      inst_ready = 1'b1;
      step();
      chk("wr_ipc_top", inst_pc, 32'hFFFF_FFFC);
      chk("wr_pcaddr_wrap", pc_addr, 32'h0);
      step();
      chk("wr_ipc_zero", inst_pc, 32'h0);
      chk("wr_halted", {31'd0, halted}, 32'd0);
      step();
      inst_ready = 1'b0;
      chk("wr_ipc_four", inst_pc, 32'h4);
`else
      br_taken  = 1'b1;
      br_target = 32'h0000_0028;
      step();
      br_taken = 1'b0;
      exp_q.push_back(32'h28);
      exp_q.push_back(32'h2C);
      exp_q.push_back(32'h30);
      exp_q.push_back(32'h34);
      inst_ready = 1'b1;
      n = 0;
      while (!halted && n < 20) begin
         step();
         n++;
      end
      chk("hl_halted", {31'd0, halted}, 32'd1);
      chk("hl_valid", {31'd0, inst_valid}, 32'd0);
      chk("hl_pcaddr", pc_addr, 32'h38);
      chk("hl_last_ipc", inst_pc, 32'h34);
      repeat (2) step();
      chk("hl_hold_pc", pc_addr, 32'h38);
      chk("hl_hold_halted", {31'd0, halted}, 32'd1);
      br_taken  = 1'b1;
      br_target = 32'h0;
      step();
      br_taken   = 1'b0;
      inst_ready = 1'b0;
      chk("hl_exit_halted", {31'd0, halted}, 32'd0);
      chk("hl_exit_pc", pc_addr, 32'h0);
      step();
      chk("hl_refetch_ipc", inst_pc, 32'h0);
      chk("hl_refetch_valid", {31'd0, inst_valid}, 32'd1);
`endif

      rst       = 1'b1;
      br_taken  = 1'b1;
      br_target = 32'h0000_0040;
      step();
      rst      = 1'b0;
      br_taken = 1'b0;
      chk("rs_pc", pc_addr, 32'd0);
      chk("rs_valid", {31'd0, inst_valid}, 32'd0);
      chk("rs_ipc", inst_pc, 32'd0);
      chk("rs_out", inst_out, 32'd0);
      chk("rs_halted", {31'd0, halted}, 32'd0);
      step();
      chk("rs_idle_valid", {31'd0, inst_valid}, 32'd0);
      chk("rs_idle_pc", pc_addr, 32'd0);
      step();
      chk("rs_fetch_valid", {31'd0, inst_valid}, 32'd1);
      chk("rs_fetch_ipc", inst_pc, 32'd0);
      chk("sb_drain", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
